// File: rtl/vc_ram_stream_reader.sv
// Streams a circular burst of words out of a combinational-read flip-flop RAM.
// Optional output register build: define VC_RAM_STREAM_READER_OREG_EN.
module vc_ram_stream_reader #(
  parameter int DATA_SZ = 32,
  parameter int ENTRIES = 8,
  parameter int ADDR_SZ = 3,
  parameter int LEN_SZ  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_val,
  output logic               cmd_rdy,
  input  logic [ADDR_SZ-1:0] cmd_addr,
  input  logic [LEN_SZ-1:0]  cmd_len,
  output logic               cmd_err,
  output logic [ADDR_SZ-1:0] raddr,
  input  logic [DATA_SZ-1:0] rdata,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [DATA_SZ-1:0] out_data,
  output logic               out_last,
  output logic               done
);

  if ((1 << ADDR_SZ) < ENTRIES) begin : g_param_check
    $error("RTL-ERROR: %m ADDR_SZ is too narrow to address ENTRIES");
  end

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             state, state_nxt;
  logic [ADDR_SZ-1:0] raddr_q, raddr_nxt, raddr_inc;
  logic [LEN_SZ-1:0]  remaining, remaining_nxt;
  logic               err_q, err_nxt, done_q, done_nxt;
  logic               cmd_bad, fetch, drain_last;

  assign raddr_inc = (raddr_q == ADDR_SZ'(ENTRIES - 1)) ? '0 : raddr_q + ADDR_SZ'(1);
  assign cmd_bad   = {1'b0, cmd_addr} >= (ADDR_SZ + 1)'(ENTRIES);
  assign raddr     = raddr_q;
  assign cmd_err   = err_q;
  assign done      = done_q;

`ifdef VC_RAM_STREAM_READER_OREG_EN
  logic               vld_p1, last_p1;
  logic [DATA_SZ-1:0] data_p1;

  // Stage p0 -> p1: RAM read lands in the output register when it is empty or draining
  assign fetch      = (state == STREAM) && (!vld_p1 || out_rdy);
  assign drain_last = vld_p1 && out_rdy && last_p1;
  assign cmd_rdy    = (state == IDLE) && !vld_p1;
  assign out_val    = vld_p1;
  assign out_data   = data_p1;
  assign out_last   = vld_p1 && last_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
    end else if (fetch) begin
      vld_p1 <= 1'b1;
    end else if (out_rdy) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (fetch) begin
      data_p1 <= rdata;
      last_p1 <= (remaining == LEN_SZ'(1));
    end
  end
`else
  assign fetch      = (state == STREAM) && out_rdy;
  assign drain_last = fetch && (remaining == LEN_SZ'(1));
  assign cmd_rdy    = (state == IDLE);
  assign out_val    = (state == STREAM);
  assign out_data   = rdata;
  assign out_last   = (state == STREAM) && (remaining == LEN_SZ'(1));
`endif

  always_comb begin
    state_nxt     = state;
    raddr_nxt     = raddr_q;
    remaining_nxt = remaining;
    err_nxt       = 1'b0;
    done_nxt      = drain_last;
    case (state)
      IDLE: begin
        if (cmd_val && cmd_rdy) begin
          if (cmd_bad) begin
            err_nxt = 1'b1;
          end else if (cmd_len == '0) begin
            done_nxt = 1'b1;
          end else begin
            raddr_nxt     = cmd_addr;
            remaining_nxt = cmd_len;
            state_nxt     = STREAM;
          end
        end
      end
      STREAM: begin
        if (fetch) begin
          raddr_nxt     = raddr_inc;
          remaining_nxt = remaining - LEN_SZ'(1);
          if (remaining == LEN_SZ'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      raddr_q   <= '0;
      remaining <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      raddr_q   <= raddr_nxt;
      remaining <= remaining_nxt;
      err_q     <= err_nxt;
      done_q    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_vc_ram_stream_reader.sv
// Directed bench for vc_ram_stream_reader against a preloaded RAM model mem[i]=0x100+i.
module tb_vc_ram_stream_reader;

`ifdef VC_RAM_STREAM_READER_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_val;
  logic        cmd_rdy;
  logic [3:0]  cmd_addr;
  logic [3:0]  cmd_len;
  logic        cmd_err;
  logic [3:0]  raddr;
  logic [31:0] rdata;
  logic        out_val;
  logic        out_rdy;
  logic [31:0] out_data;
  logic        out_last;
  logic        done;

  logic [31:0] mem [0:7];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rdata = (raddr < 4'd8) ? mem[raddr[2:0]] : 32'h0;

  vc_ram_stream_reader #(.DATA_SZ(32), .ENTRIES(8), .ADDR_SZ(4), .LEN_SZ(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_err(cmd_err), .raddr(raddr), .rdata(rdata),
    .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data), .out_last(out_last),
    .done(done)
  );

  // Called at a negedge while idle; returns at the negedge of the cycle after acceptance.
  task automatic send_cmd(input logic [3:0] a, input logic [3:0] l);
    cmd_val = 1'b1; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    cmd_val = 1'b0;
  endtask

  task automatic wait_first_word;
    for (int i = 1; i < LAT; i++) begin
      n_checks++;
      if (out_val !== 1'b0) begin n_fail++; $display("FAIL latency_out_val got %b want 0", out_val); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    n_checks++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_rdy got %b want 1", cmd_rdy); end
    n_checks++; if (out_val !== 1'b0) begin n_fail++; $display("FAIL rst_out_val got %b want 0", out_val); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last got %b want 0", out_last); end
    n_checks++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_err got %b want 0", cmd_err); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
    n_checks++; if (raddr !== 4'd0) begin n_fail++; $display("FAIL rst_raddr got %0d want 0", raddr); end
  endtask

  task automatic test_basic;
    logic [31:0] exp_d [3] = '{32'h102, 32'h103, 32'h104};
    send_cmd(4'd2, 4'd3);
    wait_first_word();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (out_val !== 1'b1) begin n_fail++; $display("FAIL basic_val[%0d] got %b want 1", i, out_val); end
      n_checks++; if (out_data !== exp_d[i]) begin n_fail++; $display("FAIL basic_data[%0d] got %h want %h", i, out_data, exp_d[i]); end
      n_checks++; if (out_last !== (i == 2)) begin n_fail++; $display("FAIL basic_last[%0d] got %b want %b", i, out_last, (i == 2)); end
      n_checks++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL basic_cmd_rdy[%0d] got %b want 0", i, cmd_rdy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_early[%0d] got %b want 0", i, done); end
      @(negedge clk);
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b want 1", done); end
    n_checks++; if (out_val !== 1'b0) begin n_fail++; $display("FAIL basic_val_after got %b want 0", out_val); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", done); end
  endtask

  task automatic test_wrap;
    logic [31:0] exp_d [4] = '{32'h106, 32'h107, 32'h100, 32'h101};
    logic [3:0]  exp_a [4] = '{4'd6, 4'd7, 4'd0, 4'd1};
    send_cmd(4'd6, 4'd4);
    wait_first_word();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (out_data !== exp_d[i]) begin n_fail++; $display("FAIL wrap_data[%0d] got %h want %h", i, out_data, exp_d[i]); end
      n_checks++; if (out_last !== (i == 3)) begin n_fail++; $display("FAIL wrap_last[%0d] got %b want %b", i, out_last, (i == 3)); end
`ifndef VC_RAM_STREAM_READER_OREG_EN
      n_checks++; if (raddr !== exp_a[i]) begin n_fail++; $display("FAIL wrap_raddr[%0d] got %0d want %0d", i, raddr, exp_a[i]); end
`endif
      @(negedge clk);
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL wrap_done got %b want 1", done); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int k = 0;
    bit started = 0;
    bit seen_done = 0;
    out_rdy = 1'b0;
    send_cmd(4'd1, 4'd4);
    for (int c = 0; c < 40 && !seen_done; c++) begin
      if (done) begin
        seen_done = 1;
      end else begin
        if (started && k < 4) begin
          n_checks++; if (out_val !== 1'b1) begin n_fail++; $display("FAIL bp_val_drop c=%0d got %b want 1", c, out_val); end
        end
        if (out_val) begin
          started = 1;
          n_checks++; if (out_data !== 32'h101 + 32'(k)) begin n_fail++; $display("FAIL bp_data k=%0d got %h want %h", k, out_data, 32'h101 + 32'(k)); end
          n_checks++; if (out_last !== (k == 3)) begin n_fail++; $display("FAIL bp_last k=%0d got %b want %b", k, out_last, (k == 3)); end
        end
        out_rdy = (c % 3 == 0);
        if (out_val && out_rdy) k++;
        @(negedge clk);
      end
    end
    out_rdy = 1'b1;
    n_checks++; if (k != 4) begin n_fail++; $display("FAIL bp_handshakes got %0d want 4", k); end
    n_checks++; if (!seen_done) begin n_fail++; $display("FAIL bp_done got 0 want 1 within budget"); end
    @(negedge clk);
  endtask

  task automatic test_edge_cmds;
    send_cmd(4'd3, 4'd0);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zlen_done got %b want 1", done); end
    n_checks++; if (out_val !== 1'b0) begin n_fail++; $display("FAIL zlen_val got %b want 0", out_val); end
    n_checks++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL zlen_cmd_rdy got %b want 1", cmd_rdy); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || out_val !== 1'b0) begin n_fail++; $display("FAIL zlen_after got done=%b val=%b want 0 0", done, out_val); end
    send_cmd(4'd9, 4'd2);
    n_checks++; if (cmd_err !== 1'b1) begin n_fail++; $display("FAIL bad_addr_err got %b want 1", cmd_err); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL bad_addr_done got %b want 0", done); end
    n_checks++; if (out_val !== 1'b0) begin n_fail++; $display("FAIL bad_addr_val got %b want 0", out_val); end
    @(negedge clk);
    n_checks++; if (cmd_err !== 1'b0 || out_val !== 1'b0) begin n_fail++; $display("FAIL bad_addr_after got err=%b val=%b want 0 0", cmd_err, out_val); end
  endtask

  task automatic test_back_to_back;
    send_cmd(4'd4, 4'd2);
    wait_first_word();
    n_checks++; if (out_data !== 32'h104) begin n_fail++; $display("FAIL b2b_d0 got %h want 104", out_data); end
    @(negedge clk);
    n_checks++; if (out_data !== 32'h105) begin n_fail++; $display("FAIL b2b_d1 got %h want 105", out_data); end
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_done_rdy got done=%b rdy=%b want 1 1", done, cmd_rdy); end
    send_cmd(4'd7, 4'd1);
    wait_first_word();
    n_checks++; if (out_val !== 1'b1 || out_data !== 32'h107 || out_last !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second got val=%b data=%h last=%b want 1 107 1", out_val, out_data, out_last);
    end
    @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done got %b want 1", done); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst;
    send_cmd(4'd0, 4'd5);
    wait_first_word();
    n_checks++; if (out_data !== 32'h100) begin n_fail++; $display("FAIL rmb_d0 got %h want 100", out_data); end
    @(negedge clk);
    n_checks++; if (out_data !== 32'h101) begin n_fail++; $display("FAIL rmb_d1 got %h want 101", out_data); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++; if (out_val !== 1'b0) begin n_fail++; $display("FAIL rmb_val got %b want 0", out_val); end
    n_checks++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL rmb_cmd_rdy got %b want 1", cmd_rdy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rmb_done got %b want 0", done); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || out_val !== 1'b0) begin n_fail++; $display("FAIL rmb_after got done=%b val=%b want 0 0", done, out_val); end
    send_cmd(4'd0, 4'd1);
    wait_first_word();
    n_checks++; if (out_val !== 1'b1 || out_data !== 32'h100 || out_last !== 1'b1) begin
      n_fail++; $display("FAIL rmb_fresh got val=%b data=%h last=%b want 1 100 1", out_val, out_data, out_last);
    end
    @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rmb_fresh_done got %b want 1", done); end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'h100 + 32'(i);
    reset_n  = 1'b0;
    cmd_val  = 1'b0;
    cmd_addr = '0;
    cmd_len  = '0;
    out_rdy  = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    out_rdy = 1'b1;
    @(negedge clk);
    test_basic();
    test_wrap();
    test_backpressure();
    test_edge_cmds();
    test_back_to_back();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vc_ram_stream_reader.md
Name: vc_ram_stream_reader

Overview:
- Read-side master for the team's 1w1r/1w2r flip-flop RAMs.
- Accepts a (start address, length) command over a val/rdy handshake.
- Drives the RAM's combinational read port and streams the words out over a val/rdy output with a last flag; the address wraps circularly at ENTRIES.
- Sits between a RAM whose write port is filled elsewhere (e.g. an FFT stage buffer) and a downstream consumer.

Parameters:
- DATA_SZ, 32: width of RAM word and out_data.
- ENTRIES, 8: number of RAM entries; wrap point.
- ADDR_SZ, 3: RAM address width; (1<<ADDR_SZ) >= ENTRIES.
- LEN_SZ, 4: width of cmd_len; maximum burst is (1<<LEN_SZ)-1 words.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_val  in  1  command valid.
- cmd_rdy  out  1  command ready.
- cmd_addr  in  ADDR_SZ  start address.
- cmd_len  in  LEN_SZ  number of words to read.
- cmd_err  out  1  one-cycle pulse: command rejected.
- raddr  out  ADDR_SZ  RAM read address.
- rdata  in  DATA_SZ  RAM read data, combinational on raddr.
- out_val  out  1  output word valid.
- out_rdy  in  1  consumer ready.
- out_data  out  DATA_SZ  output word.
- out_last  out  1  marks the final word of a burst.
- done  out  1  one-cycle pulse after the final word is accepted, or after a zero-length command.

Behaviour:
- Reset (reset_n low, asynchronous assert, synchronous deassert by the system) forces:
  - state IDLE;
  - cmd_rdy=1, cmd_err=0, out_val=0, out_last=0, done=0;
  - raddr=0, remaining-count=0.
- States: IDLE, STREAM.
- IDLE:
  - cmd_rdy=1 and out_val=0.
  - On cmd_val & cmd_rdy with cmd_addr >= ENTRIES: cmd_err=1 next cycle, command dropped, stay IDLE.
  - Else, if cmd_len==0: done=1 next cycle, stay IDLE.
  - Else: load raddr=cmd_addr and remaining=cmd_len, go to STREAM.
- STREAM:
  - cmd_rdy=0; commands are ignored and not acknowledged.
  - out_val=1, out_data=rdata (same-cycle combinational path), out_last=(remaining==1).
  - On out_val & out_rdy:
    - raddr advances: raddr==ENTRIES-1 -> 0, else raddr+1;
    - remaining decrements.
    - If out_last: go to IDLE and pulse done=1 in the next cycle.
  - When out_rdy=0: out_val, out_data (given a stable RAM) and raddr are held; out_val never drops before acceptance.
- Throughput: one word per cycle when out_rdy is held high. First out_val is 1 cycle after command acceptance.
- Back-to-back commands: a new command is accepted in the cycle done is high, because the block is IDLE in that cycle.
- Lengths greater than ENTRIES: the address keeps wrapping and words repeat; this is legal.
- Concurrent RAM write: the write lands at the clock edge, so a word is read with the value in the RAM at the cycle of presentation.
- cmd_err and done are never both high in the same cycle.
- Reset mid-burst: returns to IDLE immediately. There is no done pulse, and the remaining words are discarded.
- Non-synthesis check: print RTL-ERROR with %m if (1<<ADDR_SZ) < ENTRIES.

Optional Feature:
- Macro: VC_RAM_STREAM_READER_OREG_EN.
- Defined:
  - A 1-entry output register (data, last, valid) is inserted between rdata and out_data.
  - The RAM is read into the register whenever it is empty, or is being drained that cycle; full rate is preserved.
  - First out_val is 2 cycles after command acceptance.
  - done pulses in the cycle after the last word leaves the register.
  - cmd_rdy stays low until the register is empty.
  - Reset clears the register valid bit.
- Undefined: combinational out_data=rdata path exactly as described in Behaviour.

Test Plan:
- RAM preloaded mem[i]=0x100+i; cmd addr=2, len=3, out_rdy=1 -> outputs 0x102, 0x103, 0x104 on consecutive cycles; out_last only on 0x104; done one cycle later.
- Wrap: cmd addr=6, len=4 -> 0x106, 0x107, 0x100, 0x101; raddr goes 6, 7, 0, 1.
- Backpressure: out_rdy toggles 1,0,0,1,... during len=4 -> out_val/out_data held stable while out_rdy=0; exactly 4 handshakes in total, no duplicate or skipped word.
- Edge commands:
  - cmd len=0 -> done pulse one cycle later, out_val never high.
  - cmd addr=9 with ENTRIES=8, ADDR_SZ=4 -> cmd_err pulse, no output.
- reset_n pulsed low mid-burst after 2 of 5 words -> out_val=0 and cmd_rdy=1 immediately, no done; a fresh addr=0, len=1 command then returns 0x100.
- OREG_EN build, repeat the first and third scenarios -> identical data sequence; first out_val 2 cycles after command acceptance; sustained 1 word/cycle with out_rdy=1.
